// File: rtl/osiris_arb_pkg.sv
// osiris_arb_pkg: shared state encoding and constants for the Wishbone memory arbiter
package osiris_arb_pkg;
   typedef enum logic [1:0] {IDLE, GNT_M0, GNT_M1} state_t;
   localparam logic [2:0] FUNCT3_WORD = 3'b010;
   localparam logic       M0          = 1'b0;
   localparam logic       M1          = 1'b1;
endpackage

// File: rtl/wb_timeout_cnt.sv
// wb_timeout_cnt: 8-bit ack-wait counter that flags when the programmed limit is reached
module wb_timeout_cnt (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_clr,
   input  logic [7:0] i_limit,
   output logic       o_expired
);
   logic [7:0] r_cnt;
   // Count grant cycles, restarting whenever the grant completes or ends
   always_ff @(posedge clk) begin
      if (rst || i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + 8'd1;
   end
   assign o_expired = i_en & (r_cnt == i_limit);
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin two-master Wishbone arbiter; define WB_ARB_TIMEOUT_EN for the ack-wait timeout
module wb_mem_arbiter
   import osiris_arb_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   input  logic [2:0]            m0_funct3_i,
   output logic                  m0_ack_o,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic                  m1_ack_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [DATA_WIDTH-1:0] s_dat_o,
   output logic [2:0]            s_funct3_o,
   input  logic [DATA_WIDTH-1:0] s_dat_i,
   input  logic                  s_ack_i,
   output logic [DATA_WIDTH-1:0] m_dat_o,
   output logic                  o_core_stall,
   output logic                  o_timeout_err
);
   if (TIMEOUT_CYCLES > 255) begin : g_bad_limit
      $error("TIMEOUT_CYCLES must fit the 8-bit wait counter");
   end
   state_t                r_state, w_next;
   logic                  r_last, r_we;
   logic [ADDR_WIDTH-1:0] r_adr;
   logic [DATA_WIDTH-1:0] r_dat;
   logic [2:0]            r_f3;
   logic                  w_busy, w_grant, w_sel, w_ack, w_expired;
   assign w_busy = r_state != IDLE;
`ifdef WB_ARB_TIMEOUT_EN
   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);
   logic w_hit, r_terr;
   wb_timeout_cnt u_timeout (
      .clk       (clk),
      .rst       (rst),
      .i_en      (w_busy),
      .i_clr     (~w_busy | s_ack_i | w_expired),
      .i_limit   (LIMIT),
      .o_expired (w_hit)
   );
   assign w_expired = w_hit & ~s_ack_i;
   // Sticky record that some grant was abandoned for lack of an ack
   always_ff @(posedge clk) begin
      if (rst) r_terr <= 1'b0;
      else if (w_expired) r_terr <= 1'b1;
   end
   assign o_timeout_err = r_terr;
`else
   assign w_expired     = 1'b0;
   assign o_timeout_err = 1'b0;
`endif
   assign w_ack = w_busy & (s_ack_i | w_expired);
   // Choose next owner: round-robin from IDLE, or hand straight to the other master on a slave ack
   always_comb begin
      w_grant = 1'b0;
      w_sel   = r_last;
      if (!w_busy) begin
         w_grant = m0_stb_i | m1_stb_i;
         w_sel   = (m1_stb_i & (~m0_stb_i | (r_last == M0))) ? M1 : M0;
      end else if (s_ack_i) begin
         w_sel   = (r_state == GNT_M0) ? M1 : M0;
         w_grant = (w_sel == M1) ? m1_stb_i : m0_stb_i;
      end
      w_next = w_grant ? ((w_sel == M1) ? GNT_M1 : GNT_M0) : (w_ack ? IDLE : r_state);
   end
   // State, last-granted bit and capture of the winning master's request
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= M0;
         r_we    <= 1'b0;
         r_adr   <= '0;
         r_dat   <= '0;
         r_f3    <= '0;
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_last <= w_sel;
            r_we   <= (w_sel == M1) ? m1_we_i : m0_we_i;
            r_adr  <= (w_sel == M1) ? m1_adr_i : m0_adr_i;
            r_dat  <= (w_sel == M1) ? m1_dat_i : m0_dat_i;
            r_f3   <= (w_sel == M1) ? FUNCT3_WORD : m0_funct3_i;
         end
      end
   end
   assign s_cyc_o      = w_busy & ~w_expired;
   assign s_stb_o      = w_busy & ~w_expired;
   assign s_we_o       = r_we;
   assign s_adr_o      = r_adr;
   assign s_dat_o      = r_dat;
   assign s_funct3_o   = r_f3;
   assign m0_ack_o     = w_ack & (r_state == GNT_M0);
   assign m1_ack_o     = w_ack & (r_state == GNT_M1);
   assign m_dat_o      = (w_busy & s_ack_i) ? s_dat_i : '0;
   assign o_core_stall = m0_stb_i & ~m0_ack_o;
endmodule
